axis_packet_framer: RTL and testbench
=====================================

// Module: axis_packet_framer
// PURPOSE
//  Endpoint receiver for one axis_switch master port. Store-and-forward: buffers one whole AXIS packet,
//  then emits a byte-serial frame: SOF, TID, TUSER, LEN, then the payload bytes.
//  Sits between a switch master port and a byte link (UART/FTDI TX) toward the host.
// PARAMETERS
//  TDATA_WIDTH  8   payload width; fixed at 8, elaborated with an error if not 8
//  TID_WIDTH    8   s_axis_tid width; the low 8 bits go into the header
//  TUSER_WIDTH  8   s_axis_tuser width; the low 8 bits go into the header
//  TDEST_WIDTH  8   s_axis_tdest width; accepted and ignored (routing is already done)
//  MAX_LEN      64  maximum payload beats per packet; range 1..255; buffer depth
// PORTS
//  clk            in   1            single clock
//  resn           in   1            asynchronous active-low reset
//  s_axis_tdata   in   TDATA_WIDTH  payload from the switch master port
//  s_axis_tid     in   TID_WIDTH    source slave id; sampled on the first beat
//  s_axis_tuser   in   TUSER_WIDTH  user tag; sampled on the first beat
//  s_axis_tdest   in   TDEST_WIDTH  unused
//  s_axis_tvalid  in   1            beat valid
//  s_axis_tlast   in   1            last beat of the packet
//  s_axis_tready  out  1            high only in FILL and DROP
//  m_axis_tdata   out  8            frame byte
//  m_axis_tvalid  out  1            frame byte valid
//  m_axis_tlast   out  1            marks the final frame byte
//  m_axis_tready  in   1            downstream ready
//  frame_count    out  16           count of emitted frames; saturates at 0xFFFF
//  drop_count     out  16           count of dropped packets; saturates at 0xFFFF
// BEHAVIOUR
//  Reset (async assert, sync deassert): state=FILL, all outputs 0 except s_axis_tready=1; counters 0; buffer contents X.
//  FILL: tready=1. Each beat is written at wr_ptr, wr_ptr++. First beat latches tid[7:0] and tuser[7:0].
//   - Beat with tlast while wr_ptr<MAX_LEN: len=wr_ptr+1; go to SOF next cycle.
//   - Beat MAX_LEN is accepted without tlast: overflow; go to DROP.
//  DROP: tready=1; beats are discarded up to and including tlast; drop_count++; wr_ptr=0; return to FILL.
//   - A tlast exactly on beat MAX_LEN is NOT an overflow; the packet is framed.
//  SOF->ID->USR->LEN->PAY: tready=0. Each state presents one byte: SOF=8'hA5, tid, tuser, len, then buf[0..len-1].
//   - State advances only on m_axis_tvalid&&m_axis_tready.
//   - tdata/tlast hold stable while tvalid&&!tready (AXIS rule).
//   - Buffer read is synchronous: prefetch buf[rd_ptr] so that PAY runs 1 byte/cycle at full ready.
//   - No bubbles after the first SOF byte.
//  Last PAY byte: tlast=1, frame_count++, wr_ptr=rd_ptr=0, back to FILL on the next cycle.
//  Output frame is len+4 bytes; per-packet turnaround in FILL is >=1 cycle. tdest is ignored.
//  Reset mid-frame: the frame is truncated with no tlast; downstream must resync on SOF.
// CONFIGURATION
//  AXIS_FRAMER_CRC8_EN defined:
//   - CRC state CHK follows PAY.
//   - CRC-8 uses poly 0x07, init 0x00, MSB-first, no reflection, no final XOR.
//   - CRC covers SOF, ID, USR, LEN and payload, updated on each accepted output byte.
//   - CHK emits the CRC byte with tlast=1; the last PAY byte has tlast=0. Frame is len+5 bytes.
//  Not defined: no CHK state and no CRC logic; tlast is on the last payload byte.
// STRUCTURE
//  axis_framer_pkg holds:
//   - typedef enum logic[2:0] framer_state_t {FILL,DROP,SOF,ID,USR,LEN,PAY,CHK}
//   - localparam FRAME_SOF=8'hA5, CRC8_POLY=8'h07
//   - function crc8_byte(crc,data)
//  Sub-module axis_framer_buf: simple dual-port RAM, MAX_LEN x 8, 1 write port, 1 registered read port.
//  The top level holds the FSM, pointers, header registers, counters and the output register.
// TESTING
//  1. tid=2, tuser=0x11, data 01,02,03 (tlast on 03), m_tready=1
//     -> A5 02 11 03 01 02 03, tlast on 03, frame_count=1.
//  2. Same packet with m_tready toggling 1/0 each cycle
//     -> identical byte sequence, no dup/loss, tdata stable while stalled.
//  3. MAX_LEN=4: 6-beat packet, then 2-beat AA,BB tid=1 tuser=0
//     -> no output for the first, drop_count=1; then A5 01 00 02 AA BB.
//  4. MAX_LEN=4, 4-beat packet with tlast on beat 4
//     -> framed normally, LEN=04, drop_count=0.
//  5. Single beat 00 tid=0 tuser=0 tlast=1
//     -> A5 00 00 01 00; with AXIS_FRAMER_CRC8_EN -> A5 00 00 01 00 0B, tlast only on 0B.
//  6. resn pulsed low during PAY
//     -> m_tvalid=0 and s_tready=1 immediately; the next packet is framed from SOF; counters=0.

Source files
------------

// File: rtl/axis_framer_pkg.sv
// Shared types, constants and the CRC-8 helper for the AXIS packet framer.
package axis_framer_pkg;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    DROP = 3'd1,
    SOF  = 3'd2,
    ID   = 3'd3,
    USR  = 3'd4,
    LEN  = 3'd5,
    PAY  = 3'd6,
    CHK  = 3'd7
  } framer_state_t;

  localparam logic [7:0] FRAME_SOF = 8'hA5;
  localparam logic [7:0] CRC8_POLY = 8'h07;

  // CRC-8, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/axis_framer_buf.sv
// Packet buffer: simple dual-port RAM, one write port and one registered read port.
module axis_framer_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array and its read register are deliberately left without reset so the
  // buffer maps onto RAM primitives; stale contents are never presented downstream.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_packet_framer.sv
// Store-and-forward AXIS receiver emitting SOF/TID/TUSER/LEN/payload byte frames.
// Optional trailing CRC-8 byte when AXIS_FRAMER_CRC8_EN is defined.
module axis_packet_framer
  import axis_framer_pkg::*;
#(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 8,
  parameter int TUSER_WIDTH = 8,
  parameter int TDEST_WIDTH = 8,
  parameter int MAX_LEN     = 64
) (
  input  logic                   clk,
  input  logic                   resn,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TID_WIDTH-1:0]   s_axis_tid,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic [TDEST_WIDTH-1:0] s_axis_tdest,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  output logic                   m_axis_tlast,
  input  logic                   m_axis_tready,
  output logic [15:0]            frame_count,
  output logic [15:0]            drop_count
);

  localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] LAST_IDX = 8'(MAX_LEN - 1);
`ifdef AXIS_FRAMER_CRC8_EN
  localparam bit LAST_ON_PAY = 1'b0;
`else
  localparam bit LAST_ON_PAY = 1'b1;
`endif

  if (TDATA_WIDTH != 8) begin : g_bad_tdata
    $error("axis_packet_framer: TDATA_WIDTH must be 8");
  end
  if (TID_WIDTH < 8 || TUSER_WIDTH < 8) begin : g_bad_hdr
    $error("axis_packet_framer: TID_WIDTH and TUSER_WIDTH must be at least 8");
  end
  if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_len
    $error("axis_packet_framer: MAX_LEN must be in 1..255");
  end

  framer_state_t state;
  logic [7:0]    wr_ptr;
  logic [7:0]    rd_ptr;
  logic [7:0]    rd_next;
  logic [7:0]    len;
  logic [7:0]    hdr_tid;
  logic [7:0]    hdr_tuser;
  logic [7:0]    rd_data;
  logic          in_beat;
  logic          out_xfer;
  logic          cur_last;
  logic          pay_load;
  logic          pay_next_last;
  logic          unused_inputs;

  assign unused_inputs = ^{s_axis_tdest, s_axis_tid, s_axis_tuser};

  assign s_axis_tready = (state == FILL) || (state == DROP);
  assign in_beat       = s_axis_tvalid && s_axis_tready;
  assign out_xfer      = m_axis_tvalid && m_axis_tready;

  // rd_ptr always indexes the next payload byte; rd_data already holds buf[rd_ptr].
  assign cur_last      = (rd_ptr == len);
  assign pay_next_last = ((rd_ptr + 8'd1) == len);
  assign pay_load      = out_xfer && ((state == LEN) || (state == PAY && !cur_last));
  assign rd_next       = pay_load ? rd_ptr + 8'd1 : rd_ptr;

  axis_framer_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (in_beat && (state == FILL)),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (s_axis_tdata),
    .rd_addr (rd_next[AW-1:0]),
    .rd_data (rd_data)
  );

`ifdef AXIS_FRAMER_CRC8_EN
  logic [7:0] crc;
  logic [7:0] crc_next;

  assign crc_next = crc8_byte(crc, m_axis_tdata);

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      crc <= 8'h00;
    end else if (state == FILL) begin
      crc <= 8'h00;
    end else if (out_xfer) begin
      crc <= crc_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state         <= FILL;
      wr_ptr        <= 8'd0;
      rd_ptr        <= 8'd0;
      len           <= 8'd0;
      hdr_tid       <= 8'd0;
      hdr_tuser     <= 8'd0;
      m_axis_tdata  <= 8'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      frame_count   <= 16'd0;
      drop_count    <= 16'd0;
    end else begin
      case (state)
        FILL: if (in_beat) begin
          if (wr_ptr == 8'd0) begin
            hdr_tid   <= s_axis_tid[7:0];
            hdr_tuser <= s_axis_tuser[7:0];
          end
          if (s_axis_tlast) begin
            // The SOF byte is loaded here so it is valid on the first cycle of SOF.
            len           <= wr_ptr + 8'd1;
            rd_ptr        <= 8'd0;
            state         <= SOF;
            m_axis_tdata  <= FRAME_SOF;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
          end else if (wr_ptr == LAST_IDX) begin
            state <= DROP;
          end else begin
            wr_ptr <= wr_ptr + 8'd1;
          end
        end
        DROP: if (in_beat && s_axis_tlast) begin
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
          wr_ptr <= 8'd0;
          state  <= FILL;
        end
        SOF: if (out_xfer) begin
          m_axis_tdata <= hdr_tid;
          state        <= ID;
        end
        ID: if (out_xfer) begin
          m_axis_tdata <= hdr_tuser;
          state        <= USR;
        end
        USR: if (out_xfer) begin
          m_axis_tdata <= len;
          state        <= LEN;
        end
        LEN: if (out_xfer) begin
          m_axis_tdata <= rd_data;
          m_axis_tlast <= LAST_ON_PAY && pay_next_last;
          rd_ptr       <= rd_ptr + 8'd1;
          state        <= PAY;
        end
        PAY: if (out_xfer) begin
          if (!cur_last) begin
            m_axis_tdata <= rd_data;
            m_axis_tlast <= LAST_ON_PAY && pay_next_last;
            rd_ptr       <= rd_ptr + 8'd1;
          end else begin
`ifdef AXIS_FRAMER_CRC8_EN
            m_axis_tdata <= crc_next;
            m_axis_tlast <= 1'b1;
            state        <= CHK;
`else
            m_axis_tdata  <= 8'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            wr_ptr        <= 8'd0;
            rd_ptr        <= 8'd0;
            state         <= FILL;
            if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
`endif
          end
        end
`ifdef AXIS_FRAMER_CRC8_EN
        CHK: if (out_xfer) begin
          m_axis_tdata  <= 8'd0;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
          wr_ptr        <= 8'd0;
          rd_ptr        <= 8'd0;
          state         <= FILL;
          if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
        end
`endif
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_framer.sv
// Directed scoreboard bench for axis_packet_framer (MAX_LEN=4); follows AXIS_FRAMER_CRC8_EN.
module tb_axis_packet_framer;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef logic [7:0] pay_t [8];

  logic        clk = 1'b0;
  logic        resn;
  logic [7:0]  s_axis_tdata;
  logic [7:0]  s_axis_tid;
  logic [7:0]  s_axis_tuser;
  logic [7:0]  s_axis_tdest;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [15:0] frame_count;
  logic [15:0] drop_count;

  beat_t      exp_q[$];
  int         checks     = 0;
  int         errors     = 0;
  int         out_count  = 0;
  bit         ignore_out = 1'b1;
  bit         toggle_rdy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always #5 clk = ~clk;

  axis_packet_framer #(.MAX_LEN(4)) dut (
    .clk           (clk),
    .resn          (resn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tdest  (s_axis_tdest),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_count   (frame_count),
    .drop_count    (drop_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  // Bit-serial reference CRC-8 (poly 0x07, init 0, MSB first).
  function automatic logic [7:0] ref_crc(input logic [7:0] c, input logic [7:0] d);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[7] ^ d[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  always @(posedge clk) begin
    #1;
    m_axis_tready = toggle_rdy ? ~m_axis_tready : 1'b1;
  end

  // Output monitor: pops the scoreboard on every handshake, checks AXIS hold while stalled.
  always @(negedge clk) begin
    if (!resn || ignore_out) begin
      prev_stall = 1'b0;
      if (resn && m_axis_tvalid && m_axis_tready) out_count++;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_axis_tvalid, 1);
        check("stall_data", m_axis_tdata, prev_data);
        check("stall_last", m_axis_tlast, prev_last);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        out_count++;
        check("byte_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          beat_t e;
          e = exp_q.pop_front();
          check("out_data", m_axis_tdata, e.data);
          check("out_last", m_axis_tlast, e.last);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  task automatic send_pkt(input logic [7:0] tid, input logic [7:0] tuser, input int n,
                          input pay_t d, input bit framed);
    logic [7:0] crc;
    crc = 8'h00;
    if (framed) begin
      logic [7:0] hdr [4];
      hdr = '{8'hA5, tid, tuser, 8'(n)};
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back(beat_t'{hdr[i], 1'b0});
        crc = ref_crc(crc, hdr[i]);
      end
      for (int i = 0; i < n; i++) begin
`ifdef AXIS_FRAMER_CRC8_EN
        exp_q.push_back(beat_t'{d[i], 1'b0});
`else
        exp_q.push_back(beat_t'{d[i], i == n - 1});
`endif
        crc = ref_crc(crc, d[i]);
      end
`ifdef AXIS_FRAMER_CRC8_EN
      exp_q.push_back(beat_t'{crc, 1'b1});
`endif
    end
    for (int i = 0; i < n; i++) begin
      int w;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d[i];
      s_axis_tid    = (i == 0) ? tid : 8'($urandom);
      s_axis_tuser  = (i == 0) ? tuser : 8'($urandom);
      s_axis_tdest  = 8'($urandom);
      s_axis_tlast  = (i == n - 1);
      w = 0;
      @(negedge clk);
      while (!s_axis_tready && w < 200) begin
        @(negedge clk);
        w++;
      end
      check("beat_accept", s_axis_tready, 1);
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
    check(tag, exp_q.size(), 0);
    #1;
  endtask

  initial begin
    int base;
    resn          = 1'b0;
    s_axis_tdata  = 8'h00;
    s_axis_tid    = 8'h00;
    s_axis_tuser  = 8'h00;
    s_axis_tdest  = 8'h00;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_s_tready", s_axis_tready, 1);
    check("rst_frame_count", frame_count, 0);
    check("rst_drop_count", drop_count, 0);
    resn       = 1'b1;
    ignore_out = 1'b0;

    // 1: basic three-byte packet, downstream always ready
    send_pkt(8'h02, 8'h11, 3, '{8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 0}, 1'b1);
    drain("t1_drain");
    check("t1_frame_count", frame_count, 1);

    // 2: same packet with downstream ready toggling
    toggle_rdy = 1'b1;
    send_pkt(8'h02, 8'h11, 3, '{8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 0}, 1'b1);
    drain("t2_drain");
    toggle_rdy = 1'b0;
    check("t2_frame_count", frame_count, 2);

    // 3: oversize packet dropped, following packet framed
    send_pkt(8'h05, 8'h06, 6, '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 0, 0}, 1'b0);
    check("t3_drop_count", drop_count, 1);
    send_pkt(8'h01, 8'h00, 2, '{8'hAA, 8'hBB, 0, 0, 0, 0, 0, 0}, 1'b1);
    drain("t3_drain");
    check("t3_frame_count", frame_count, 3);

    // 4: exactly MAX_LEN beats with tlast on the last one is not an overflow
    send_pkt(8'h03, 8'h04, 4, '{8'h11, 8'h22, 8'h33, 8'h44, 0, 0, 0, 0}, 1'b1);
    drain("t4_drain");
    check("t4_drop_count", drop_count, 1);
    check("t4_frame_count", frame_count, 4);

    // 5: single zero byte
    send_pkt(8'h00, 8'h00, 1, '{8'h00, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
    drain("t5_drain");
    check("t5_frame_count", frame_count, 5);

    // 6: reset asserted while the payload is streaming
    ignore_out = 1'b1;
    base       = out_count;
    send_pkt(8'h09, 8'h0A, 4, '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 0, 0, 0, 0}, 1'b0);
    for (int i = 0; i < 200 && out_count < base + 5; i++) @(posedge clk);
    #1;
    check("t6_reached_pay", 32'(out_count >= base + 5), 1);
    check("t6_pre_rst_tvalid", m_axis_tvalid, 1);
    resn = 1'b0;
    #1;
    check("t6_rst_m_tvalid", m_axis_tvalid, 0);
    check("t6_rst_m_tlast", m_axis_tlast, 0);
    check("t6_rst_s_tready", s_axis_tready, 1);
    check("t6_rst_frame_count", frame_count, 0);
    check("t6_rst_drop_count", drop_count, 0);
    @(posedge clk);
    #1;
    resn = 1'b1;
    exp_q.delete();
    ignore_out = 1'b0;
    send_pkt(8'h07, 8'h08, 1, '{8'h5A, 0, 0, 0, 0, 0, 0, 0}, 1'b1);
    drain("t6_drain");
    check("t6_frame_count", frame_count, 1);
    check("t6_drop_count", drop_count, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
